// File: rtl/ifetch_pkg.sv
// Shared types and constants for the sequential instruction-fetch unit.
package ifetch_pkg;

   typedef enum logic [1:0] {
      StReq,
      StWait,
      StHold,
      StHalt
   } state_e;

   localparam int unsigned INST_BYTES = 4;
   localparam int unsigned JIDX_W     = 26;  // j/jal instruction index field
   localparam int unsigned WADDR_W    = 30;  // word-address part of a branch target

endpackage

// File: rtl/ifetch_seq_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface ifetch_seq_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/ifetch_seq_next_pc_sel.sv
// Priority mux for the next PC: jr, then j/jal, then taken branch, then PC+4.
module next_pc_sel
   import ifetch_pkg::*;
(
   input  logic [31:0] pc_plus_4,
   input  logic [31:0] instruction,
   input  logic [31:0] addr_result,
   input  logic [31:0] read_data_1,
   input  logic        branch,
   input  logic        nbranch,
   input  logic        jmp,
   input  logic        jal,
   input  logic        jr,
   input  logic        zero,
   output logic [31:0] next_pc,
   output logic        taken
);

   assign taken = (branch & zero) | (nbranch & ~zero);

   always_comb begin
      next_pc = pc_plus_4;
      if (jr) begin
         next_pc = {read_data_1[31:2], 2'b00};
      end else if (jmp | jal) begin
         next_pc = {pc_plus_4[31:28], instruction[JIDX_W-1:0], 2'b00};
      end else if (taken) begin
         next_pc = {addr_result[WADDR_W-1:0], 2'b00};
      end
   end

   logic unused_bits;
   assign unused_bits = ^{instruction[31:JIDX_W], addr_result[31:WADDR_W], read_data_1[1:0]};

endmodule

// File: rtl/ifetch_seq.sv
// Sequential fetch unit: owns the PC, fetches one word at a time, holds it until accepted.
// Optional IFETCH_MISALIGN_EN: a misaligned jr target halts fetch and raises sticky misalign.
module ifetch_seq
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset,
   ifetch_seq_if.master        imem,
   output logic [31:0]         Instruction,
   output logic                inst_valid,
   input  logic                inst_accept,
   input  logic                Branch,
   input  logic                nBranch,
   input  logic                Jmp,
   input  logic                Jal,
   input  logic                Jr,
   input  logic                Zero,
   input  logic [31:0]         Addr_Result,
   input  logic [31:0]         Read_data_1,
`ifdef IFETCH_MISALIGN_EN
   output logic                misalign,
`endif
   output logic [31:0]         PC_plus_4,
   output logic [31:0]         link_addr
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic [31:0] link_q, link_d;
   logic        req;
   logic [31:0] next_pc;
   logic        unused_taken;
`ifdef IFETCH_MISALIGN_EN
   logic        mis_q, mis_d;
`endif

   assign PC_plus_4 = pc_q + 32'(INST_BYTES);

   next_pc_sel u_next_pc_sel (
      .pc_plus_4   (PC_plus_4),
      .instruction (inst_q),
      .addr_result (Addr_Result),
      .read_data_1 (Read_data_1),
      .branch      (Branch),
      .nbranch     (nBranch),
      .jmp         (Jmp),
      .jal         (Jal),
      .jr          (Jr),
      .zero        (Zero),
      .next_pc     (next_pc),
      .taken       (unused_taken)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      link_d  = link_q;
      req     = 1'b0;
`ifdef IFETCH_MISALIGN_EN
      mis_d   = mis_q;
`endif
      case (state_q)
         StReq: begin
            req     = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            req = 1'b1;
            if (imem.imem_ready) begin
               inst_d  = imem.imem_rdata;
               valid_d = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            // Redirect inputs only matter in the accept cycle.
            if (inst_accept) begin
               valid_d = 1'b0;
               state_d = StReq;
               pc_d    = next_pc;
               if (Jal) link_d = PC_plus_4;
`ifdef IFETCH_MISALIGN_EN
               if (Jr && (Read_data_1[1:0] != 2'b00)) begin
                  pc_d    = pc_q;
                  mis_d   = 1'b1;
                  state_d = StHalt;
               end
`endif
            end
         end
         StHalt: ;
         default: state_d = StReq;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StReq;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         valid_q <= 1'b0;
         link_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         link_q  <= link_d;
      end
   end

`ifdef IFETCH_MISALIGN_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) mis_q <= 1'b0;
      else       mis_q <= mis_d;
   end
   assign misalign = mis_q;
`endif

   // Gating with reset drops the request the instant reset rises.
   assign imem.imem_req  = req & ~reset;
   assign imem.imem_addr = pc_q;
   assign Instruction    = inst_q;
   assign inst_valid     = valid_q;
   assign link_addr      = link_q;

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Sequential instruction-fetch unit that owns the PC and consumes the execute stage's branch outputs (Addr_Result, Zero) plus the Jr operand (Read_data_1).
- Requests words from instruction memory over a req/ready handshake.
- Presents one instruction at a time to decode/execute and holds it until accepted.
- Computes the next PC from branch/jump/jr decisions and produces PC_plus_4 and the jal link address.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of requested word.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory response strobe, 1 cycle.
- Instruction  out  32  held instruction.
- inst_valid  out  1  Instruction is valid.
- inst_accept  in  1  consumer takes Instruction this cycle.
- Branch  in  1  beq decoded.
- nBranch  in  1  bne decoded.
- Jmp  in  1  j decoded.
- Jal  in  1  jal decoded.
- Jr  in  1  jr decoded.
- Zero  in  1  ALU zero flag.
- Addr_Result  in  32  branch target, word address.
- Read_data_1  in  32  jr target, byte address.
- PC_plus_4  out  32  address of held instruction + 4.
- link_addr  out  32  return address latched on jal.

Behaviour:
- Clock port is clock; reset is asynchronous and active-high.
- Reset values (applied immediately, mid-transaction included): PC=RESET_PC, state=REQ, imem_req=0, imem_addr=RESET_PC, Instruction=0, inst_valid=0, PC_plus_4=RESET_PC+4, link_addr=0. A response arriving during or after reset for the aborted request is ignored.
- State REQ: one cycle; imem_req=1, imem_addr=PC; go to WAIT.
- State WAIT:
  - imem_req stays 1 and imem_addr stays stable until imem_ready=1.
  - On imem_ready, Instruction<=imem_rdata, inst_valid<=1; go to HOLD.
  - imem_ready while not in WAIT is ignored.
- State HOLD:
  - inst_valid=1, imem_req=0.
  - Redirect inputs are sampled only in the cycle where inst_accept=1; they are ignored otherwise.
  - On accept: PC<=next_pc, inst_valid<=0; go to REQ.
- Minimum issue interval is 3 cycles: REQ, WAIT with an immediate ready, then HOLD with an immediate accept.
- PC_plus_4 = PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- next_pc priority (highest first):
  - Jr: {Read_data_1[31:2],2'b00}.
  - Jmp or Jal: {PC_plus_4[31:28],Instruction[25:0],2'b00}.
  - Taken branch, taken=(Branch&Zero)|(nBranch&~Zero): {Addr_Result[29:0],2'b00}.
  - Otherwise PC_plus_4.
- Simultaneous decode flags resolve by the priority above and are not flagged as an error.
- Jal additionally sets link_addr<=PC_plus_4 on the accept cycle; link_addr holds otherwise.
- Branch and Zero must be stable in the accept cycle. Execute is combinational from the held Instruction, so this is guaranteed by construction.

Optional Feature:
- Macro IFETCH_MISALIGN_EN.
- Without it: Jr target low bits are silently forced to 00.
- With it:
  - Adds output misalign (1 bit, reset 0) and state HALT.
  - An accepted Jr with Read_data_1[1:0]!=0 sets misalign=1 (sticky), leaves PC unchanged, and enters HALT.
  - In HALT: imem_req=0 and inst_valid=0 until reset.

Decomposition:
- Shared package ifetch_pkg:
  - state encoding (REQ, WAIT, HOLD, HALT);
  - constant INST_BYTES=4;
  - jump/branch target field widths (26-bit index, 30-bit word address).
- Natural sub-module next_pc_sel: combinational priority mux computing next_pc and the taken flag. The FSM and registers stay in ifetch_seq.

Test Plan:
- Reset with RESET_PC=0, memory ready 1 cycle after req, accept immediate → imem_addr sequence 0,4,8,C; Instruction matches memory; one issue every 3 cycles.
- beq with Zero=1, Addr_Result=32'h0000_0010 at accept → next imem_addr=32'h40. Same case with Zero=0 → PC+4.
- jal at PC=32'h0040_0008, Instruction[25:0]=26'h000_0100 → next imem_addr=32'h0000_0400; link_addr=32'h0040_000C.
- Jr=1 and Jmp=1 together, Read_data_1=32'h0000_0080 → next imem_addr=32'h80 (Jr wins).
- Memory ready delayed 5 cycles, and inst_accept held low for 4 cycles with Branch toggling → imem_addr and Instruction stable throughout; branch ignored until the accept cycle.
- Reset asserted mid-WAIT with a late imem_ready → imem_req drops immediately, the stale response is discarded, and the first post-reset fetch is RESET_PC. With IFETCH_MISALIGN_EN: Jr to 32'h82 → misalign=1, no further imem_req.
